psum_mem_arbiter: RTL
=====================

Name: psum_mem_arbiter

Overview:
Single-port arbiter for the partial-sum accumulator SRAM. It shares one read-or-write access per cycle between the convolution controller (write of the previous psum plus read of the next psum, often in the same cycle) and a host drain/readout port. It contains a 1-entry posted-write buffer with read forwarding, so simultaneous controller read+write rarely stall. A starvation counter guarantees host progress.

Parameters:
ADDR_W, 20, SRAM address width
DATA_W, 32, psum word width
HOST_MAX_WAIT, 16, max consecutive cycles host_req may wait before a forced host grant (>=1)

Ports:
clk  in  1  clock
rst_in  in  1  synchronous reset, active high
ctrl_we  in  1  controller write request
ctrl_waddr  in  ADDR_W  controller write address
ctrl_wdata  in  DATA_W  controller write data
ctrl_re  in  1  controller read request
ctrl_raddr  in  ADDR_W  controller read address
ctrl_stall  out  1  ctrl requests not accepted this cycle; controller holds them unchanged
ctrl_rvalid  out  1  ctrl read data valid
ctrl_rdata  out  DATA_W  ctrl read data
host_req  in  1  host read request
host_addr  in  ADDR_W  host read address
host_ready  out  1  host request accepted this cycle
host_rvalid  out  1  host read data valid
host_rdata  out  DATA_W  host read data
sram_en  out  1  SRAM access enable
sram_we  out  1  SRAM write (1) / read (0)
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  DATA_W  SRAM write data
sram_rdata  in  DATA_W  SRAM read data, 1 cycle after read enable
stall_count  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Clock clk; reset rst_in synchronous, active high. On reset: all outputs 0, write buffer invalid, wait counter 0, stall_count 0. Reset mid-operation discards a buffered write and in-flight read returns.
- State: wbuf_valid/wbuf_addr/wbuf_data; host_wait counter; 1-cycle read-return tag (NONE/CTRL/CTRL_FWD/HOST) plus forwarded-data register.
- Per-cycle priority (first match wins):
  1. Forced host: host_req && host_wait==HOST_MAX_WAIT -> SRAM read host_addr, host_ready=1, ctrl_stall=1 if ctrl_we|ctrl_re.
  2. ctrl_re && ctrl_we && wbuf_valid -> SRAM writes wbuf, wbuf cleared, ctrl_stall=1.
  3. ctrl_re (with or without ctrl_we) -> if wbuf_valid && ctrl_raddr==wbuf_addr: no SRAM access, return wbuf_data (forward); else SRAM read ctrl_raddr. If ctrl_we, new write enters wbuf. Same-cycle ctrl_raddr==ctrl_waddr returns the pre-write value.
  4. ctrl_we only -> wbuf empty: direct SRAM write. wbuf full: SRAM writes wbuf, new write enters wbuf.
  5. No ctrl request, wbuf_valid -> SRAM writes wbuf.
  6. Else host_req -> SRAM read host_addr, host_ready=1.
- Read latency: ctrl_rvalid/host_rvalid exactly 1 cycle after acceptance; rdata muxed from sram_rdata or forwarded register per tag. Rvalid pulses 1 cycle.
- host_wait: reset to 0 when host_ready or !host_req; else +1, saturating at HOST_MAX_WAIT.
- sram_* outputs combinational from the decision; sram_en=0 when no access.
- Host reads do not snoop wbuf. Host reads only after controller idle/flush (system rule).

Optional Feature:
PSUM_ARB_PERF_EN: defined -> stall_count increments each cycle ctrl_stall=1, saturating at 2^32-1, cleared by reset. Undefined -> counter not built, stall_count tied to 0.

Test Plan:
- Reset mid-buffer: write 0x5@A3 with concurrent read of A9 (buffered), assert rst_in -> next cycle all outputs 0; read A3 later returns old SRAM value.
- Simultaneous R/W: ctrl_we A1=0x10 + ctrl_re A2 (A2 holds 0x7), wbuf empty -> no stall, ctrl_rvalid next cycle, rdata=0x7; A1 written on next idle cycle.
- Forwarding: buffered A1=0x10, then ctrl_re A1 -> sram_en=0 that cycle, rdata=0x10 after 1 cycle.
- Buffer full + R/W: wbuf holds A1, ctrl_we A4 + ctrl_re A5 -> ctrl_stall=1 one cycle, sram writes A1; following cycle accepted without stall.
- Starvation: HOST_MAX_WAIT=4, continuous ctrl_re, host_req A8 -> host_ready on 5th request cycle, ctrl_stall=1 that cycle, host_rvalid next cycle with SRAM[A8].
- Perf counter (macro defined): 3 stall cycles -> stall_count=3; undefined -> stays 0.

Source files
------------

// File: rtl/psum_mem_arbiter_if.sv
// ============================================================================
// Module   : psum_mem_arbiter_if
// Summary  : Controller, host and SRAM signal bundle for psum_mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface psum_mem_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
);
    logic              ctrl_we;
    logic [ADDR_W-1:0] ctrl_waddr;
    logic [DATA_W-1:0] ctrl_wdata;
    logic              ctrl_re;
    logic [ADDR_W-1:0] ctrl_raddr;
    logic              ctrl_stall;
    logic              ctrl_rvalid;
    logic [DATA_W-1:0] ctrl_rdata;
    logic              host_req;
    logic [ADDR_W-1:0] host_addr;
    logic              host_ready;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;
    logic              sram_en;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;
    logic [31:0]       stall_count;

    // Requester side: controller, host and the SRAM macro's read port.
    modport master (
        output ctrl_we, ctrl_waddr, ctrl_wdata, ctrl_re, ctrl_raddr,
        output host_req, host_addr, sram_rdata,
        input  ctrl_stall, ctrl_rvalid, ctrl_rdata,
        input  host_ready, host_rvalid, host_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata, stall_count
    );

    modport slave (
        input  ctrl_we, ctrl_waddr, ctrl_wdata, ctrl_re, ctrl_raddr,
        input  host_req, host_addr, sram_rdata,
        output ctrl_stall, ctrl_rvalid, ctrl_rdata,
        output host_ready, host_rvalid, host_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata, stall_count
    );
endinterface

`default_nettype wire

// File: rtl/psum_mem_arbiter.sv
// ============================================================================
// Module   : psum_mem_arbiter
// Summary  : Single-port psum SRAM arbiter with a 1-entry posted-write buffer,
//            read forwarding and host starvation guard.
// Options  : PSUM_ARB_PERF_EN - builds the saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module psum_mem_arbiter #(
    parameter int ADDR_W        = 20,
    parameter int DATA_W        = 32,
    parameter int HOST_MAX_WAIT = 16
) (
    input  wire logic           clk,
    input  wire logic           rst_in,
    psum_mem_arbiter_if.slave   bus
);

    localparam int c_WAIT_W = $clog2(HOST_MAX_WAIT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(HOST_MAX_WAIT);

    localparam logic [1:0] c_TAG_NONE = 2'd0;
    localparam logic [1:0] c_TAG_CTRL = 2'd1;
    localparam logic [1:0] c_TAG_FWD  = 2'd2;
    localparam logic [1:0] c_TAG_HOST = 2'd3;

    logic                r_wbuf_valid;
    logic [ADDR_W-1:0]   r_wbuf_addr;
    logic [DATA_W-1:0]   r_wbuf_data;
    logic [c_WAIT_W-1:0] r_host_wait;
    logic [1:0]          r_tag;
    logic [DATA_W-1:0]   r_fwd_data;

    logic                w_sram_en;
    logic                w_sram_we;
    logic [ADDR_W-1:0]   w_sram_addr;
    logic [DATA_W-1:0]   w_sram_wdata;
    logic                w_host_ready;
    logic                w_ctrl_stall;
    logic                w_wbuf_load;
    logic                w_wbuf_clear;
    logic                w_fwd_load;
    logic [1:0]          w_tag_nxt;
    logic                w_forced;

    assign w_forced = bus.host_req && (r_host_wait == c_WAIT_MAX);

    // Access decision; reset suppresses every access and handshake.
    always_comb begin
        w_sram_en    = 1'b0;
        w_sram_we    = 1'b0;
        w_sram_addr  = '0;
        w_sram_wdata = '0;
        w_host_ready = 1'b0;
        w_ctrl_stall = 1'b0;
        w_wbuf_load  = 1'b0;
        w_wbuf_clear = 1'b0;
        w_fwd_load   = 1'b0;
        w_tag_nxt    = c_TAG_NONE;
        if (rst_in) begin
            w_tag_nxt = c_TAG_NONE;
        end else if (w_forced) begin
            w_sram_en    = 1'b1;
            w_sram_addr  = bus.host_addr;
            w_host_ready = 1'b1;
            w_ctrl_stall = bus.ctrl_we | bus.ctrl_re;
            w_tag_nxt    = c_TAG_HOST;
        end else if (bus.ctrl_re && bus.ctrl_we && r_wbuf_valid) begin
            w_sram_en    = 1'b1;
            w_sram_we    = 1'b1;
            w_sram_addr  = r_wbuf_addr;
            w_sram_wdata = r_wbuf_data;
            w_wbuf_clear = 1'b1;
            w_ctrl_stall = 1'b1;
        end else if (bus.ctrl_re) begin
            if (r_wbuf_valid && (bus.ctrl_raddr == r_wbuf_addr)) begin
                w_fwd_load = 1'b1;
                w_tag_nxt  = c_TAG_FWD;
            end else begin
                w_sram_en   = 1'b1;
                w_sram_addr = bus.ctrl_raddr;
                w_tag_nxt   = c_TAG_CTRL;
            end
            // Only reachable with an empty buffer, so the read sees pre-write data.
            w_wbuf_load = bus.ctrl_we;
        end else if (bus.ctrl_we) begin
            w_sram_en = 1'b1;
            w_sram_we = 1'b1;
            if (r_wbuf_valid) begin
                w_sram_addr  = r_wbuf_addr;
                w_sram_wdata = r_wbuf_data;
                w_wbuf_load  = 1'b1;
            end else begin
                w_sram_addr  = bus.ctrl_waddr;
                w_sram_wdata = bus.ctrl_wdata;
            end
        end else if (r_wbuf_valid) begin
            w_sram_en    = 1'b1;
            w_sram_we    = 1'b1;
            w_sram_addr  = r_wbuf_addr;
            w_sram_wdata = r_wbuf_data;
            w_wbuf_clear = 1'b1;
        end else if (bus.host_req) begin
            w_sram_en    = 1'b1;
            w_sram_addr  = bus.host_addr;
            w_host_ready = 1'b1;
            w_tag_nxt    = c_TAG_HOST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_wbuf_valid <= 1'b0;
            r_wbuf_addr  <= '0;
            r_wbuf_data  <= '0;
            r_host_wait  <= '0;
            r_tag        <= c_TAG_NONE;
            r_fwd_data   <= '0;
        end else begin
            if (w_wbuf_load) begin
                r_wbuf_valid <= 1'b1;
                r_wbuf_addr  <= bus.ctrl_waddr;
                r_wbuf_data  <= bus.ctrl_wdata;
            end else if (w_wbuf_clear) begin
                r_wbuf_valid <= 1'b0;
            end
            if (w_host_ready || !bus.host_req) begin
                r_host_wait <= '0;
            end else if (r_host_wait != c_WAIT_MAX) begin
                r_host_wait <= r_host_wait + c_WAIT_W'(1);
            end
            r_tag <= w_tag_nxt;
            if (w_fwd_load) begin
                r_fwd_data <= r_wbuf_data;
            end
        end
    end

    assign bus.sram_en     = w_sram_en;
    assign bus.sram_we     = w_sram_we;
    assign bus.sram_addr   = w_sram_addr;
    assign bus.sram_wdata  = w_sram_wdata;
    assign bus.host_ready  = w_host_ready;
    assign bus.ctrl_stall  = w_ctrl_stall;
    assign bus.ctrl_rvalid = (r_tag == c_TAG_CTRL) || (r_tag == c_TAG_FWD);
    assign bus.ctrl_rdata  = (r_tag == c_TAG_FWD)  ? r_fwd_data :
                             (r_tag == c_TAG_CTRL) ? bus.sram_rdata : '0;
    assign bus.host_rvalid = (r_tag == c_TAG_HOST);
    assign bus.host_rdata  = (r_tag == c_TAG_HOST) ? bus.sram_rdata : '0;

`ifdef PSUM_ARB_PERF_EN
    logic [31:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_stall_count <= '0;
        end else if (w_ctrl_stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign bus.stall_count = r_stall_count;
`else
    assign bus.stall_count = '0;
`endif

endmodule

`default_nettype wire
